riscv_muldiv_ctrl: RTL and testbench

RISCV_MULDIV_CTRL -- requirements
Module: riscv_muldiv_ctrl

---
 rtl/riscv_muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_riscv_muldiv_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_ctrl.sv
// RV32M multiply/divide unit: iterative shift-add multiplier and restoring divider, 32 cycles per op.
// Define MULDIV_DIV_EN to build the divider; without it, divide ops complete at once with result 0.
module riscv_muldiv_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd3} state_t;
`endif

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, opnd;
    logic [1:0]  op_q;
    logic        sign_a_q, sign_b_q;

    logic        accept, in_calc, last;
    logic        a_signed, b_signed, sign_a, sign_b;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [31:0] mul_hi, mul_lo, mul_res;
    logic [63:0] prod_mag, prod;
    logic [31:0] step_hi, step_lo, step_res;

    assign accept = (state == ST_IDLE) && start_i && !kill_i;
    assign last   = (cnt == 5'd31);
`ifdef MULDIV_DIV_EN
    assign in_calc = (state == ST_MUL) || (state == ST_DIV);
`else
    assign in_calc = (state == ST_MUL);
`endif

    // Operand signedness: DIV/REM have funct3[0]=0; MULHU is the only unsigned-rs1 multiply.
    assign a_signed = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
    assign sign_a   = a_signed && rs1_i[31];
    assign sign_b   = b_signed && rs2_i[31];
    assign a_mag    = sign_a ? -rs1_i : rs1_i;
    assign b_mag    = sign_b ? -rs2_i : rs2_i;

    // Multiply step: acc_lo holds the remaining multiplier bits and fills with product low bits.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    assign mul_hi   = mul_sum[32:1];
    assign mul_lo   = {mul_sum[0], acc_lo[31:1]};
    assign prod_mag = {mul_hi, mul_lo};
    assign prod     = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    assign mul_res  = (op_q == 2'b00) ? prod[31:0] : prod[63:32];

`ifdef MULDIV_DIV_EN
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_hi, div_lo, quot, rem, div_res;

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_hi    = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
    assign div_lo    = {acc_lo[30:0], div_ge};
    assign quot      = (opnd == 32'd0) ? 32'hFFFF_FFFF
                     : ((sign_a_q ^ sign_b_q) ? -div_lo : div_lo);
    assign rem       = sign_a_q ? -div_hi : div_hi;
    assign div_res   = op_q[1] ? rem : quot;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        step_hi  = mul_hi;
        step_lo  = mul_lo;
        step_res = mul_res;
`ifdef MULDIV_DIV_EN
        if (state == ST_DIV) begin
            step_hi  = div_hi;
            step_lo  = div_lo;
            step_res = div_res;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kill_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
`ifdef MULDIV_DIV_EN
                    state_nxt = funct3_i[2] ? ST_DIV : ST_MUL;
`else
                    state_nxt = funct3_i[2] ? ST_DONE : ST_MUL;
`endif
                end
                ST_MUL:  if (last) state_nxt = ST_DONE;
`ifdef MULDIV_DIV_EN
                ST_DIV:  if (last) state_nxt = ST_DONE;
`endif
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state == ST_IDLE);
        busy_o  = (state != ST_IDLE);
        done_o  = (state == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opnd     <= 32'd0;
            op_q     <= 2'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_o <= 32'd0;
        end else if (accept) begin
            op_q     <= funct3_i[1:0];
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            cnt      <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= funct3_i[2] ? a_mag : b_mag;
            opnd     <= funct3_i[2] ? b_mag : a_mag;
`ifndef MULDIV_DIV_EN
            if (funct3_i[2]) result_o <= 32'd0;
`endif
        end else if (in_calc && !kill_i) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (last) result_o <= step_res;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_ctrl.sv
// Directed bench for riscv_muldiv_ctrl: latency, sign rules, divide corner cases, kill and reset.
module tb_riscv_muldiv_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'd0;

`ifdef MULDIV_DIV_EN
    localparam int DIV_LAT = 32;
`else
    localparam int DIV_LAT = 0;
`endif

    riscv_muldiv_ctrl dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dx(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    // Issue one op from IDLE; lat counts edges after the accepting edge until done_o shows.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic busy_ok;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " busy"}, {31'd0, busy_ok & busy_o}, 32'd1);
        tick();
        check({tag, " done pulse"}, {30'd0, done_o, ready_o}, 32'd1);
        last_res = exp;
    endtask

    initial begin
        int n;
        int rc;
        logic [2:0]  rf;
        logic [31:0] rexp;

        tick();
        tick();
        check("reset ready/busy/done", {29'd0, ready_o, busy_o, done_o}, 32'd4);
        check("reset result", result_o, 32'd0);
        rst_i = 1'b0;

        run_op("MUL 7*-3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run_op("MULHU -1*-1",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run_op("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32);
        run_op("MULHSU -1*-1",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_op("DIV overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dx(32'h8000_0000), DIV_LAT);
        run_op("REM overflow",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dx(32'h0000_0000), DIV_LAT);
        run_op("REM -7 by 2",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, dx(32'hFFFF_FFFF), DIV_LAT);
        run_op("DIVU by 0",       3'b101, 32'h0000_0064, 32'h0000_0000, dx(32'hFFFF_FFFF), DIV_LAT);
        run_op("REMU by 0",       3'b111, 32'h0000_0064, 32'h0000_0000, dx(32'h0000_0064), DIV_LAT);
        run_op("DIV -7 by 0",     3'b100, 32'hFFFF_FFF9, 32'h0000_0000, dx(32'hFFFF_FFFF), DIV_LAT);
        run_op("DIV 100/-7",      3'b100, 32'h0000_0064, 32'hFFFF_FFF9, dx(32'hFFFF_FFF2), DIV_LAT);
        run_op("MUL 0x10000*0x10000", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32);

        // Kill at counter 10: next cycle IDLE, no done, result held, then immediate re-accept.
        funct3_i = 3'b000;
        rs1_i    = 32'd3;
        rs2_i    = 32'd4;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        repeat (10) tick();
        check("kill pre busy", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill ready/busy/done", {29'd0, ready_o, busy_o, done_o}, 32'd4);
        check("kill result held", result_o, last_res);
        run_op("MUL after kill", 3'b000, 32'd3, 32'd4, 32'd12, 32);

        // Kill during DONE still shows the done pulse.
        funct3_i = 3'b000;
        rs1_i    = 32'd2;
        rs2_i    = 32'd3;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        repeat (32) tick();
        kill_i = 1'b1;
        check("kill in DONE done", {31'd0, done_o}, 32'd1);
        check("kill in DONE result", result_o, 32'd6);
        tick();
        kill_i = 1'b0;
        check("after DONE kill ready", {30'd0, ready_o, done_o}, 32'd2);

        // start_i held high, reset mid-operation, then back-to-back accepts every 34 cycles.
`ifdef MULDIV_DIV_EN
        rf   = 3'b100;
        rexp = 32'd14;
`else
        rf   = 3'b000;
        rexp = 32'd700;
`endif
        funct3_i = rf;
        rs1_i    = 32'd100;
        rs2_i    = 32'd7;
        start_i  = 1'b1;
        tick();
        repeat (5) tick();
        check("pre-reset busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid-op reset ready/busy/done", {29'd0, ready_o, busy_o, done_o}, 32'd4);
        check("mid-op reset result", result_o, 32'd0);
        tick();
        n = 0;
        while (!done_o && n < 40) begin
            tick();
            n++;
        end
        check("held-start latency", 32'(n), 32'd32);
        check("held-start result", result_o, rexp);
        n  = 0;
        rc = 0;
        do begin
            tick();
            n++;
            if (ready_o) rc++;
        end while (!done_o && n < 80);
        check("back-to-back spacing", 32'(n), 32'd34);
        check("back-to-back ready cycles", 32'(rc), 32'd1);
        check("back-to-back result", result_o, rexp);
        start_i = 1'b0;
        tick();
        check("final idle", {29'd0, ready_o, busy_o, done_o}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
